// File: rtl/wave_sample_sequencer.sv
// wave_sample_sequencer
//
// Upstream sample source for FIR_Filter. Holds a writable waveform table and
// plays it out as a paced sample stream, with a programmable rate divider,
// finite or infinite loop count, and start/stop control.
//
// Build option:
//   SEQ_OFFSET_BIN_EN  defined: table words are offset-binary and the MSB is
//                      inverted on the way to data_out (two's complement out).
//                      undefined: table words pass through unchanged.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset (table is not cleared)
//   wr_en         table write strobe (accepted in any state)
//   wr_addr       table write address
//   wr_data       table write data
//   start         begin playback, sampled only in IDLE
//   stop          abort playback, wins over a same-cycle sample issue
//   rate_div      one sample every rate_div+1 clocks, latched at start
//   loop_count    number of table passes, 0 = infinite, latched at start
//   data_out      registered sample to the FIR, 0 while idle
//   sample_valid  one-cycle strobe when data_out takes a table sample
//   busy          high in RUN and DONE
//   done          one-cycle pulse after the final pass completes

module wave_sample_sequencer #(
   parameter int unsigned N      = 16,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DIV_W  = 8,
   parameter int unsigned LOOP_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [N-1:0]      wr_data,
   input  logic              start,
   input  logic              stop,
   input  logic [DIV_W-1:0]  rate_div,
   input  logic [LOOP_W-1:0] loop_count,
   output logic [N-1:0]      data_out,
   output logic              sample_valid,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state;
   logic [N-1:0]      mem [DEPTH];
   logic [ADDR_W-1:0] rd_addr;
   logic [DIV_W-1:0]  div_cnt;
   logic [LOOP_W-1:0] pass_cnt;
   logic [DIV_W-1:0]  rate_q;
   logic [LOOP_W-1:0] loop_q;
   // Set when the final sample has been issued; done follows one edge later.
   logic              last_q;

   // Table word to output format.
   function automatic logic [N-1:0] to_out(input logic [N-1:0] w);
`ifdef SEQ_OFFSET_BIN_EN
      return {~w[N-1], w[N-2:0]};
`else
      return w;
`endif
   endfunction

   // Waveform table: synchronous write, no reset, read-before-write by NBA.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Playback FSM with registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         data_out     <= '0;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         rd_addr      <= '0;
         div_cnt      <= '0;
         pass_cnt     <= '0;
         rate_q       <= '0;
         loop_q       <= '0;
         last_q       <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         done         <= 1'b0;
         case (state)
            S_IDLE: begin
               data_out <= '0;
               busy     <= 1'b0;
               last_q   <= 1'b0;
               if (start && !stop) begin
                  state    <= S_RUN;
                  busy     <= 1'b1;
                  rate_q   <= rate_div;
                  loop_q   <= loop_count;
                  rd_addr  <= '0;
                  div_cnt  <= '0;
                  pass_cnt <= '0;
               end
            end

            S_RUN: begin
               if (stop) begin
                  state    <= S_IDLE;
                  busy     <= 1'b0;
                  data_out <= '0;
                  last_q   <= 1'b0;
               end else if (last_q) begin
                  // data_out keeps the last sample through DONE
                  state  <= S_DONE;
                  done   <= 1'b1;
                  last_q <= 1'b0;
               end else if (div_cnt == rate_q) begin
                  div_cnt      <= '0;
                  data_out     <= to_out(mem[rd_addr]);
                  sample_valid <= 1'b1;
                  rd_addr      <= rd_addr + ADDR_W'(1);
                  if (rd_addr == LAST_ADDR) begin
                     // pass_cnt wraps silently when looping forever
                     pass_cnt <= pass_cnt + LOOP_W'(1);
                     if ((loop_q != '0) && (pass_cnt + LOOP_W'(1) == loop_q)) begin
                        last_q <= 1'b1;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wave_sample_sequencer.sv
// Directed self-checking bench for wave_sample_sequencer.
module tb_wave_sample_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic        start;
   logic        stop;
   logic [7:0]  rate_div;
   logic [7:0]  loop_count;
   logic [15:0] data_out;
   logic        sample_valid;
   logic        busy;
   logic        done;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] tbl [32];

   wave_sample_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .start        (start),
      .stop         (stop),
      .rate_div     (rate_div),
      .loop_count   (loop_count),
      .data_out     (data_out),
      .sample_valid (sample_valid),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] exp_out(input logic [15:0] w);
`ifdef SEQ_OFFSET_BIN_EN
      return w ^ 16'h8000;
`else
      return w;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [15:0] d);
      wr_en   = 1'b1;
      wr_addr = 5'(a);
      wr_data = d;
      tick();
      wr_en   = 1'b0;
      tbl[a]  = d;
   endtask

   task automatic test_reset();
      reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; stop = 1'b0; rate_div = '0; loop_count = '0;
      repeat (2) tick();
      n_assert++;
      if (data_out !== 16'h0 || sample_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: data_out=%h sv=%b busy=%b done=%b, required 0000 0 0 0",
                  data_out, sample_valid, busy, done);
      end
      reset = 1'b1;
      tick();
      for (int i = 0; i < 32; i++) wr(i, 16'(i * 256));
   endtask

   task automatic test_single_pass();
      rate_div = 8'd0; loop_count = 8'd1; start = 1'b1;
      tick();
      start = 1'b0;
      n_assert++;
      if (busy !== 1'b1 || sample_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL sp_start: busy=%b sv=%b, required 1 0", busy, sample_valid);
      end
      for (int i = 0; i < 32; i++) begin
         tick();
         n_assert++;
         if (sample_valid !== 1'b1 || data_out !== exp_out(tbl[i]) || done !== 1'b0) begin
            n_fail++;
            $display("FAIL sp_sample[%0d]: sv=%b data=%h done=%b, required 1 %h 0",
                     i, sample_valid, data_out, done, exp_out(tbl[i]));
         end
      end
      tick();
      n_assert++;
      if (done !== 1'b1 || busy !== 1'b1 || sample_valid !== 1'b0 || data_out !== exp_out(tbl[31])) begin
         n_fail++;
         $display("FAIL sp_done: done=%b busy=%b sv=%b data=%h, required 1 1 0 %h",
                  done, busy, sample_valid, data_out, exp_out(tbl[31]));
      end
      tick();
      n_assert++;
      if (done !== 1'b0 || busy !== 1'b0 || data_out !== exp_out(tbl[31])) begin
         n_fail++;
         $display("FAIL sp_after_done: done=%b busy=%b data=%h, required 0 0 %h",
                  done, busy, data_out, exp_out(tbl[31]));
      end
      tick();
      n_assert++;
      if (data_out !== 16'h0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL sp_idle_flush: data=%h busy=%b, required 0000 0", data_out, busy);
      end
   endtask

   task automatic test_rate_loop2();
      rate_div = 8'd3; loop_count = 8'd2; start = 1'b1;
      tick();
      start = 1'b0;
      // changes after start must not matter
      rate_div = 8'd0; loop_count = 8'd5;
      for (int s = 0; s < 64; s++) begin
         for (int g = 0; g < 3; g++) begin
            tick();
            n_assert++;
            if (sample_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL rl_gap[%0d.%0d]: sv=%b done=%b busy=%b, required 0 0 1",
                        s, g, sample_valid, done, busy);
            end
         end
         tick();
         n_assert++;
         if (sample_valid !== 1'b1 || data_out !== exp_out(tbl[s % 32])) begin
            n_fail++;
            $display("FAIL rl_sample[%0d]: sv=%b data=%h, required 1 %h",
                     s, sample_valid, data_out, exp_out(tbl[s % 32]));
         end
      end
      tick();
      n_assert++;
      if (done !== 1'b1 || sample_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rl_done: done=%b sv=%b, required 1 0", done, sample_valid);
      end
      tick();
      n_assert++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rl_end: done=%b busy=%b, required 0 0", done, busy);
      end
   endtask

   task automatic test_infinite_stop();
      rate_div = 8'd0; loop_count = 8'd0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         n_assert++;
         if (sample_valid !== 1'b1 || data_out !== exp_out(tbl[i % 32]) || done !== 1'b0) begin
            n_fail++;
            $display("FAIL inf_sample[%0d]: sv=%b data=%h done=%b, required 1 %h 0",
                     i, sample_valid, data_out, done, exp_out(tbl[i % 32]));
         end
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_assert++;
      if (data_out !== 16'h0 || busy !== 1'b0 || sample_valid !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL inf_stop: data=%h busy=%b sv=%b done=%b, required 0000 0 0 0",
                  data_out, busy, sample_valid, done);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_assert++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL inf_post_stop[%0d]: done=%b busy=%b, required 0 0", i, done, busy);
         end
      end
   endtask

   task automatic test_start_ignored();
      rate_div = 8'd0; loop_count = 8'd1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      start = 1'b1;
      tick();
      n_assert++;
      if (sample_valid !== 1'b1 || data_out !== exp_out(tbl[5])) begin
         n_fail++;
         $display("FAIL si_run_start: sv=%b data=%h, required 1 %h", sample_valid, data_out, exp_out(tbl[5]));
      end
      start = 1'b0;
      tick();
      n_assert++;
      if (sample_valid !== 1'b1 || data_out !== exp_out(tbl[6]) || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL si_continue: sv=%b data=%h busy=%b, required 1 %h 1",
                  sample_valid, data_out, busy, exp_out(tbl[6]));
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_assert++;
      if (busy !== 1'b0 || data_out !== 16'h0) begin
         n_fail++;
         $display("FAIL si_stop: busy=%b data=%h, required 0 0000", busy, data_out);
      end
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      n_assert++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL si_start_stop_idle: busy=%b, required 0", busy);
      end
      tick();
      n_assert++;
      if (busy !== 1'b0 || sample_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL si_stay_idle: busy=%b sv=%b, required 0 0", busy, sample_valid);
      end
   endtask

   task automatic test_rbw();
      logic [15:0] old;
      rate_div = 8'd0; loop_count = 8'd2; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      old     = tbl[10];
      wr_en   = 1'b1; wr_addr = 5'd10; wr_data = 16'hABCD;
      tick();
      wr_en   = 1'b0;
      tbl[10] = 16'hABCD;
      n_assert++;
      if (sample_valid !== 1'b1 || data_out !== exp_out(old)) begin
         n_fail++;
         $display("FAIL rbw_old: sv=%b data=%h, required 1 %h", sample_valid, data_out, exp_out(old));
      end
      for (int i = 11; i < 42; i++) tick();
      tick();
      n_assert++;
      if (sample_valid !== 1'b1 || data_out !== exp_out(16'hABCD)) begin
         n_fail++;
         $display("FAIL rbw_new: sv=%b data=%h, required 1 %h", sample_valid, data_out, exp_out(16'hABCD));
      end
      for (int i = 43; i < 64; i++) tick();
      tick();
      n_assert++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL rbw_done: done=%b, required 1", done);
      end
      tick();
      wr(10, 16'h0A00);
   endtask

   task automatic test_async_reset();
      rate_div = 8'd0; loop_count = 8'd0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      #2 reset = 1'b0;
      #1;
      n_assert++;
      if (data_out !== 16'h0 || sample_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL ar_immediate: data=%h sv=%b busy=%b done=%b, required 0000 0 0 0",
                  data_out, sample_valid, busy, done);
      end
      tick();
      reset = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_assert++;
         if (sample_valid !== 1'b1 || data_out !== exp_out(tbl[i])) begin
            n_fail++;
            $display("FAIL ar_restart[%0d]: sv=%b data=%h, required 1 %h",
                     i, sample_valid, data_out, exp_out(tbl[i]));
         end
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic test_offset();
      logic [15:0] e0;
      logic [15:0] e1;
`ifdef SEQ_OFFSET_BIN_EN
      e0 = 16'h0000; e1 = 16'h7FFF;
`else
      e0 = 16'h8000; e1 = 16'hFFFF;
`endif
      wr(0, 16'h8000);
      wr(1, 16'hFFFF);
      rate_div = 8'd0; loop_count = 8'd0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      n_assert++;
      if (data_out !== e0) begin
         n_fail++;
         $display("FAIL ofs_word0: data=%h, required %h", data_out, e0);
      end
      tick();
      n_assert++;
      if (data_out !== e1) begin
         n_fail++;
         $display("FAIL ofs_word1: data=%h, required %h", data_out, e1);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_rate_loop2();
      test_infinite_stop();
      test_start_ignored();
      test_rbw();
      test_async_reset();
      test_offset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
